accelerator: RTL and testbench



---
 rtl/accel_pkg.sv | 26 ++
 rtl/dp_ram.sv | 26 ++
 rtl/accelerator.sv | 186 ++++++++++++++++++
 tb/tb_accelerator.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/accel_pkg.sv
// accel_pkg: shared widths, CSR word indices, engine states and result saturation for the accelerator tile.
package accel_pkg;
    localparam int DATA_W      = 32;
    localparam int CSR_ADDR_W  = 6;
    localparam int FRAM_ADDR_W = 10;
    localparam int KRAM_ADDR_W = 10;
    localparam int CSR_IDX_W   = CSR_ADDR_W - 2;
    localparam int NUM_CSR     = 10;

    typedef logic [CSR_IDX_W-1:0] csr_idx_t;

    localparam csr_idx_t CSR_CMD    = csr_idx_t'(0);
    localparam csr_idx_t CSR_FSRC   = csr_idx_t'(1);
    localparam csr_idx_t CSR_KSRC   = csr_idx_t'(2);
    localparam csr_idx_t CSR_DST    = csr_idx_t'(7);
    localparam csr_idx_t CSR_LEN    = csr_idx_t'(8);
    localparam csr_idx_t CSR_SHIFT  = csr_idx_t'(9);
    localparam csr_idx_t CSR_STATUS = csr_idx_t'(10);

    typedef enum logic [1:0] {IDLE, RUN, WB, DONE} state_t;

    function automatic logic [31:0] sat32(input logic signed [63:0] v);
        return (v > 64'sh7FFF_FFFF) ? 32'h7FFF_FFFF :
               (v < -64'sh8000_0000) ? 32'h8000_0000 : v[31:0];
    endfunction
endpackage

// File: rtl/dp_ram.sv
// dp_ram: true dual-port RAM with 1-cycle registered reads; port A wins a same-address write collision.
module dp_ram #(
    parameter int AW = 10,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          a_en,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic [DW-1:0] a_rdata,
    input  logic          b_en,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic [DW-1:0] b_rdata
);
    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (b_en && b_we) mem[b_addr] <= b_wdata;
        if (a_en && a_we) mem[a_addr] <= a_wdata;
        if (a_en) a_rdata <= mem[a_addr];
        if (b_en) b_rdata <= mem[b_addr];
    end
endmodule

// File: rtl/accelerator.sv
// accelerator: AXI4-Lite CSR slave plus FRAM/KRAM dot-product engine writing a shifted, saturated result back to FRAM.
module accelerator
    import accel_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = DATA_W,
    parameter int C_S_AXI_ADDR_WIDTH = CSR_ADDR_W,
    parameter int FRAM_ADDR_WIDTH    = FRAM_ADDR_W,
    parameter int KRAM_ADDR_WIDTH    = KRAM_ADDR_W
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
    input  logic [2:0]                      s00_axi_awprot,
    input  logic                            s00_axi_awvalid,
    output logic                            s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
    input  logic                            s00_axi_wvalid,
    output logic                            s00_axi_wready,
    output logic [1:0]                      s00_axi_bresp,
    output logic                            s00_axi_bvalid,
    input  logic                            s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
    input  logic [2:0]                      s00_axi_arprot,
    input  logic                            s00_axi_arvalid,
    output logic                            s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
    output logic [1:0]                      s00_axi_rresp,
    output logic                            s00_axi_rvalid,
    input  logic                            s00_axi_rready,
    input  logic [FRAM_ADDR_WIDTH+1:0]      fram_addr_byteidx,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   fram_wdata,
    input  logic                            fram_we,
    input  logic                            fram_en,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   fram_rdata,
    input  logic [KRAM_ADDR_WIDTH+1:0]      kram_addr_byteidx,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   kram_wdata,
    input  logic                            kram_we,
    input  logic                            kram_en,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   kram_rdata,
    output logic                            compute_done
);
    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int FA = FRAM_ADDR_WIDTH;
    localparam int KA = KRAM_ADDR_WIDTH;

    logic [DW-1:0]      csr [NUM_CSR];
    logic               aw_full, w_hs, start, busy, p_vld, wb_wait;
    csr_idx_t           aw_idx, ar_idx;
    logic [DW-1:0]      rd_val, len, idx, fb_rdata, kb_rdata, wb_data;
    state_t             state, state_n;
    logic [FA-1:0]      f_base, dst_w, fb_addr;
    logic [KA-1:0]      k_base, kb_addr;
    logic [5:0]         shift;
    logic signed [63:0] acc, product;
    logic               unused;

    assign s00_axi_bresp = 2'b00;
    assign s00_axi_rresp = 2'b00;
    assign w_hs   = s00_axi_wready && s00_axi_wvalid;
    assign ar_idx = csr_idx_t'(s00_axi_araddr >> 2);
    assign busy   = state != IDLE;
    assign start  = w_hs && aw_idx == CSR_CMD && s00_axi_wstrb[0] && s00_axi_wdata[0] && !busy;
    assign unused = ^{s00_axi_awprot, s00_axi_arprot, fram_addr_byteidx[1:0], kram_addr_byteidx[1:0]};

    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NUM_CSR; i++) if (ar_idx == csr_idx_t'(i)) rd_val = csr[i];
        if (ar_idx == CSR_STATUS) rd_val = {{(DW-2){1'b0}}, compute_done, busy};
    end

    // AW and W are accepted independently; the latched address gates W acceptance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s00_axi_awready <= 1'b0;
            s00_axi_wready  <= 1'b0;
            s00_axi_bvalid  <= 1'b0;
            s00_axi_arready <= 1'b0;
            s00_axi_rvalid  <= 1'b0;
            s00_axi_rdata   <= '0;
            aw_full         <= 1'b0;
            aw_idx          <= '0;
            for (int i = 0; i < NUM_CSR; i++) csr[i] <= '0;
        end else begin
            s00_axi_awready <= s00_axi_awvalid && !aw_full && !s00_axi_awready;
            s00_axi_wready  <= s00_axi_wvalid && aw_full && !s00_axi_wready;
            s00_axi_arready <= s00_axi_arvalid && !s00_axi_arready && !s00_axi_rvalid;
            if (s00_axi_awready && s00_axi_awvalid) begin
                aw_full <= 1'b1;
                aw_idx  <= csr_idx_t'(s00_axi_awaddr >> 2);
            end
            if (w_hs) begin
                aw_full        <= 1'b0;
                s00_axi_bvalid <= 1'b1;
                for (int i = 0; i < NUM_CSR; i++)
                    for (int b = 0; b < DW/8; b++)
                        if (aw_idx == csr_idx_t'(i) && s00_axi_wstrb[b]) csr[i][8*b +: 8] <= s00_axi_wdata[8*b +: 8];
            end else if (s00_axi_bready) begin
                s00_axi_bvalid <= 1'b0;
            end
            if (s00_axi_arready && s00_axi_arvalid) begin
                s00_axi_rvalid <= 1'b1;
                s00_axi_rdata  <= rd_val;
            end else if (s00_axi_rready) begin
                s00_axi_rvalid <= 1'b0;
            end
        end
    end

    // WB spends one cycle letting the last product land in acc, then writes
    always_comb begin
        state_n = state;
        case (state)
            IDLE: state_n = start ? ((csr[CSR_LEN] == '0) ? WB : RUN) : IDLE;
            RUN:  state_n = (idx == len - 1'b1) ? WB : RUN;
            WB:   state_n = wb_wait ? WB : DONE;
            DONE: state_n = IDLE;
        endcase
    end

    assign fb_addr = (state == WB) ? dst_w : f_base + idx[FA-1:0];
    assign kb_addr = k_base + idx[KA-1:0];
    assign product = 64'($signed(fb_rdata)) * 64'($signed(kb_rdata));
    assign wb_data = sat32(acc >>> shift);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            f_base       <= '0;
            k_base       <= '0;
            dst_w        <= '0;
            len          <= '0;
            idx          <= '0;
            shift        <= '0;
            acc          <= '0;
            p_vld        <= 1'b0;
            wb_wait      <= 1'b0;
            compute_done <= 1'b0;
        end else begin
            state   <= state_n;
            p_vld   <= state == RUN;
            wb_wait <= state != WB;
            if (state == RUN) idx <= idx + 1'b1;
            if (p_vld) acc <= acc + product;
            if (state == DONE) compute_done <= 1'b1;
            if (start) begin
                f_base       <= csr[CSR_FSRC][FA+1:2];
                k_base       <= csr[CSR_KSRC][KA+1:2];
                dst_w        <= csr[CSR_DST][FA+1:2];
                len          <= csr[CSR_LEN];
                shift        <= csr[CSR_SHIFT][5:0];
                idx          <= '0;
                acc          <= '0;
                compute_done <= 1'b0;
            end
        end
    end

    dp_ram #(.AW(FA), .DW(DW)) u_fram (
        .clk     (clk),
        .a_en    (fram_en),
        .a_we    (fram_we),
        .a_addr  (fram_addr_byteidx[FA+1:2]),
        .a_wdata (fram_wdata),
        .a_rdata (fram_rdata),
        .b_en    (1'b1),
        .b_we    (state == WB && !wb_wait),
        .b_addr  (fb_addr),
        .b_wdata (wb_data),
        .b_rdata (fb_rdata)
    );

    dp_ram #(.AW(KA), .DW(DW)) u_kram (
        .clk     (clk),
        .a_en    (kram_en),
        .a_we    (kram_we),
        .a_addr  (kram_addr_byteidx[KA+1:2]),
        .a_wdata (kram_wdata),
        .a_rdata (kram_rdata),
        .b_en    (1'b1),
        .b_we    (1'b0),
        .b_addr  (kb_addr),
        .b_wdata ('0),
        .b_rdata (kb_rdata)
    );
endmodule

// File: tb/tb_accelerator.sv
// tb_accelerator: directed self-checking bench for the accelerator CSR slave, RAM ports and dot-product engine.
module tb_accelerator;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [5:0]  awaddr = '0, araddr = '0;
    logic [2:0]  awprot = '0, arprot = '0;
    logic        awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0, bready = 1'b1, rready = 1'b1;
    logic        awready, wready, bvalid, arready, rvalid, compute_done;
    logic [31:0] wdata = '0, rdata;
    logic [3:0]  wstrb = '0;
    logic [1:0]  bresp, rresp;
    logic [11:0] fram_addr = '0, kram_addr = '0;
    logic [31:0] fram_wdata = '0, kram_wdata = '0, fram_rdata, kram_rdata;
    logic        fram_we = 1'b0, fram_en = 1'b0, kram_we = 1'b0, kram_en = 1'b0;
    int          checks = 0, errors = 0, cyc = 0, w_cyc = 0;

    accelerator dut (
        .clk(clk), .rst_n(rst_n),
        .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
        .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
        .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
        .s00_axi_araddr(araddr), .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
        .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid), .s00_axi_rready(rready),
        .fram_addr_byteidx(fram_addr), .fram_wdata(fram_wdata), .fram_we(fram_we), .fram_en(fram_en), .fram_rdata(fram_rdata),
        .kram_addr_byteidx(kram_addr), .kram_wdata(kram_wdata), .kram_we(kram_we), .kram_en(kram_en), .kram_rdata(kram_rdata),
        .compute_done(compute_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        awaddr = a;
        awvalid = 1'b1;
        while (awready !== 1'b1 && n < 20) begin tick(); n++; end
        check("awready", awready, 1);
        tick();
        awvalid = 1'b0;
        wdata = d;
        wstrb = s;
        wvalid = 1'b1;
        n = 0;
        while (wready !== 1'b1 && n < 20) begin tick(); n++; end
        check("wready", wready, 1);
        tick();
        wvalid = 1'b0;
        w_cyc = cyc;
    endtask

    task automatic axi_read(input logic [5:0] a, output logic [31:0] d);
        int n = 0;
        araddr = a;
        arvalid = 1'b1;
        while (arready !== 1'b1 && n < 20) begin tick(); n++; end
        tick();
        arvalid = 1'b0;
        check("rvalid", rvalid, 1);
        d = rdata;
        tick();
    endtask

    task automatic ram_wr(input bit k, input int w, input logic [31:0] d);
        if (k) begin
            kram_addr = {w[9:0], 2'b00}; kram_wdata = d; kram_we = 1'b1; kram_en = 1'b1;
        end else begin
            fram_addr = {w[9:0], 2'b00}; fram_wdata = d; fram_we = 1'b1; fram_en = 1'b1;
        end
        tick();
        kram_we = 1'b0; kram_en = 1'b0; fram_we = 1'b0; fram_en = 1'b0;
    endtask

    task automatic ram_rd(input bit k, input int w, output logic [31:0] d);
        if (k) begin kram_addr = {w[9:0], 2'b00}; kram_en = 1'b1; end
        else begin fram_addr = {w[9:0], 2'b00}; fram_en = 1'b1; end
        tick();
        kram_en = 1'b0; fram_en = 1'b0;
        d = k ? kram_rdata : fram_rdata;
    endtask

    task automatic wait_done(output int lat);
        int n = 0;
        while (compute_done !== 1'b1 && n < 300) begin tick(); n++; end
        lat = cyc - w_cyc;
    endtask

    task automatic run_check(input string tag, input int len, input logic [31:0] exp);
        int lat;
        logic [31:0] d;
        axi_write(6'h00, 32'h1, 4'hF);
        wait_done(lat);
        check({tag, "_lat"}, lat, len + 3);
        ram_rd(0, 16, d);
        check(tag, d, exp);
    endtask

    initial begin
        logic [31:0] d;
        int lat, s;
        #2 rst_n = 1'b0;
        repeat (3) tick();
        check("rst_awready", awready, 0);
        check("rst_wready", wready, 0);
        check("rst_bvalid", bvalid, 0);
        check("rst_arready", arready, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_rdata", rdata, 0);
        check("rst_resp", {bresp, rresp}, 0);
        check("rst_done", compute_done, 0);
        rst_n = 1'b1;
        tick();
        axi_read(6'h28, d); check("status_rst", d, 0);
        axi_read(6'h20, d); check("len_rst", d, 0);

        axi_write(6'h04, 32'h4200_0000, 4'hF);
        axi_write(6'h0C, 32'd100, 4'hF);
        axi_write(6'h20, 32'd49, 4'hF);
        axi_write(6'h24, 32'd15, 4'hF);
        axi_read(6'h04, d); check("csr_fsrc", d, 32'h4200_0000);
        axi_read(6'h0C, d); check("csr_cfg0", d, 32'd100);
        axi_read(6'h20, d); check("csr_len", d, 32'd49);
        axi_read(6'h24, d); check("csr_shift", d, 32'd15);
        axi_read(6'h3C, d); check("csr_unmapped_rd", d, 0);
        axi_write(6'h30, 32'hFFFF_FFFF, 4'hF);
        axi_read(6'h30, d); check("csr_unmapped_wr", d, 0);
        axi_write(6'h10, 32'h1122_3344, 4'hF);
        axi_write(6'h10, 32'hAABB_CCDD, 4'b0010);
        axi_read(6'h10, d); check("csr_wstrb", d, 32'h1122_CC44);

        ram_wr(0, 2, 32'hDEAD_BEEF);
        ram_rd(0, 2, d); check("fram_port", d, 32'hDEAD_BEEF);

        for (int i = 0; i < 4; i++) begin
            ram_wr(0, i, 32'(i + 1));
            ram_wr(1, i, 32'(i + 5));
        end
        axi_write(6'h04, 32'h0, 4'hF);
        axi_write(6'h08, 32'h0, 4'hF);
        axi_write(6'h1C, 32'h40, 4'hF);
        axi_write(6'h20, 32'd4, 4'hF);
        axi_write(6'h24, 32'd0, 4'hF);
        axi_write(6'h00, 32'h0302_FFE1, 4'hF);
        wait_done(lat);
        check("dot_lat", lat, 7);
        axi_read(6'h28, d); check("dot_status", d, 32'h2);
        ram_rd(0, 16, d); check("dot_result", d, 32'd70);
        axi_read(6'h00, d); check("cmd_readback", d, 32'h0302_FFE1);

        axi_write(6'h20, 32'd1, 4'hF);
        ram_wr(0, 0, 32'h7FFF_FFFF);
        ram_wr(1, 0, 32'd4);
        run_check("sat_pos", 1, 32'h7FFF_FFFF);
        axi_write(6'h24, 32'd34, 4'hF);
        run_check("shr34", 1, 32'h0);
        axi_write(6'h24, 32'd32, 4'hF);
        run_check("shr32", 1, 32'h1);
        axi_write(6'h24, 32'd0, 4'hF);
        ram_wr(0, 0, 32'h8000_0000);
        run_check("sat_neg", 1, 32'h8000_0000);
        ram_wr(0, 0, 32'hFFFF_FFFD);
        ram_wr(1, 0, 32'd5);
        axi_write(6'h24, 32'd1, 4'hF);
        run_check("neg_shift", 1, 32'hFFFF_FFF8);

        ram_wr(0, 16, 32'h1234_5678);
        axi_write(6'h20, 32'd0, 4'hF);
        run_check("len0", 0, 32'h0);

        for (int i = 0; i < 12; i++) begin
            ram_wr(0, i, 32'(i + 1));
            ram_wr(1, i, 32'd1);
        end
        axi_write(6'h24, 32'd0, 4'hF);
        axi_write(6'h20, 32'd12, 4'hF);
        axi_write(6'h00, 32'h1, 4'hF);
        s = w_cyc;
        axi_write(6'h00, 32'h1, 4'hF);
        axi_read(6'h28, d); check("busy_status", d, 32'h1);
        w_cyc = s;
        wait_done(lat);
        check("busy_lat", lat, 15);
        ram_rd(0, 16, d); check("busy_result", d, 32'd78);

        axi_write(6'h04, 32'h4200_0FFC, 4'hF);
        axi_write(6'h20, 32'd2, 4'hF);
        ram_wr(0, 1023, 32'd3);
        run_check("wrap", 2, 32'd4);

        ram_wr(0, 16, 32'hA5A5_A5A5);
        repeat (20) tick();
        ram_rd(0, 16, d); check("no_extra_wb", d, 32'hA5A5_A5A5);
        axi_read(6'h28, d); check("idle_status", d, 32'h2);

        axi_write(6'h04, 32'h0, 4'hF);
        axi_write(6'h20, 32'd12, 4'hF);
        axi_write(6'h00, 32'h1, 4'hF);
        axi_read(6'h28, d); check("run_status", d, 32'h1);
        rst_n = 1'b0;
        #1;
        check("abort_done", compute_done, 0);
        tick();
        rst_n = 1'b1;
        tick();
        axi_read(6'h28, d); check("abort_status", d, 0);
        axi_read(6'h20, d); check("abort_len", d, 0);
        ram_rd(0, 16, d); check("abort_ram_keep", d, 32'hA5A5_A5A5);
        axi_write(6'h1C, 32'h40, 4'hF);
        axi_write(6'h20, 32'd12, 4'hF);
        run_check("rerun", 12, 32'd78);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
